// File: rtl/z80_intc_pkg.sv
// Shared types and constants for the Z80 vectored interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package z80_intc_pkg;

  // Request/acknowledge sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } intc_state_e;

  // Register offsets inside the I/O window
  localparam logic [1:0] REG_MASK  = 2'd0;
  localparam logic [1:0] REG_VBASE = 2'd1;
  localparam logic [1:0] REG_EOI   = 2'd2;
  localparam logic [1:0] REG_PEND  = 2'd3;

  // Byte returned when an acknowledge finds nothing eligible
  localparam logic [7:0] SPURIOUS_VEC = 8'hFF;
  localparam logic [7:0] MASK_RST     = 8'hFF;

  // RETI opcode pair (ED 4D)
  localparam logic [7:0] OP_ED   = 8'hED;
  localparam logic [7:0] OP_RETI = 8'h4D;

  // IM2 vector: base high nibble, source index, even address
  function automatic logic [7:0] mk_vector(input logic [7:0] vbase, input logic [2:0] w);
    return {vbase[7:4], w, 1'b0};
  endfunction

endpackage

// File: rtl/z80_intc_if.sv
// CPU-side bus bundle between the TV80 core and the interrupt controller.
// Latency: n/a (wiring only).
// Backpressure: none; the CPU owns all strobes.
interface z80_intc_if;
  logic       m1_n;
  logic       mreq_n;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] addr;
  logic [7:0] cpu_do;
  logic [7:0] fetch_d;
  logic [7:0] dout;
  logic       dout_en;
  logic       int_n;

  // CPU side: drives strobes, address and data, receives vector/read data and int_n
  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, addr, cpu_do, fetch_d,
    input  dout, dout_en, int_n
  );

  // Controller side
  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, addr, cpu_do, fetch_d,
    output dout, dout_en, int_n
  );
endinterface

// File: rtl/z80_intc_prio.sv
// Fixed-priority encoder: bit 0 wins, reports valid + index of lowest set bit.
// Latency: combinational.
// Backpressure: none.
module z80_intc_prio #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec,
  output logic         vld,
  output logic [2:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    vld = 1'b0;
    idx = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        vld = 1'b1;
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/z80_int_ctrl.sv
// Eight-source vectored interrupt controller for TV80: edge-latched requests, mask, nesting, IM2 vector.
// Latency: irq edge -> pending +1 clk -> int_n low +2 clk; ack -> vector/dout_en +1 clk; I/O read data +1 clk.
// Backpressure: none; follows CPU strobes. Optional RETI snoop under Z80_INTC_RETI_SNOOP_EN.
module z80_int_ctrl
  import z80_intc_pkg::*;
#(
  parameter int         NSRC    = 8,
  parameter logic [7:0] IO_BASE = 8'hF0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq,
  z80_intc_if.slave       bus
);

  intc_state_e     state_q, state_d;
  logic [NSRC-1:0] irq_q, irq_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] in_service_q, in_service_d;
  logic [7:0]      mask_q, mask_d;
  logic [7:0]      vbase_q, vbase_d;
  logic [7:0]      dout_q, dout_d;
  logic            dout_en_q, dout_en_d;
  logic            int_n_q, int_n_d;
  logic            io_wr_q, io_wr_d;

  logic [NSRC-1:0] irq_edge, allowed, eligible;
  logic            isv_vld, win_vld;
  logic [2:0]      isv_idx, win_idx;
  logic [7:0]      io_off, rd_data, pend_rd;
  logic            io_hit, io_rd, io_wr_act, io_wr, ack, ack_take, eoi, reti_pulse;

  assign bus.dout    = dout_q;
  assign bus.dout_en = dout_en_q;
  assign bus.int_n   = int_n_q;

  // Highest-priority source currently in service
  z80_intc_prio #(.N(NSRC)) u_prio_isv (
    .vec (in_service_q),
    .vld (isv_vld),
    .idx (isv_idx)
  );

  // Highest-priority eligible request
  z80_intc_prio #(.N(NSRC)) u_prio_win (
    .vec (eligible),
    .vld (win_vld),
    .idx (win_idx)
  );

  // Eligibility: unmasked pending requests that outrank everything in service
  always_comb begin
    irq_edge = irq & ~irq_q;
    allowed  = '0;
    for (int i = 0; i < NSRC; i++) begin
      allowed[i] = !isv_vld || (3'(i) < isv_idx);
    end
    eligible = pending_q & ~mask_q[NSRC-1:0] & allowed;
  end

  // Bus decode: window hit, register read mux, single-shot write strobe, ack cycle
  always_comb begin
    io_off    = bus.addr - IO_BASE;
    io_hit    = (io_off[7:2] == 6'd0);
    io_rd     = !bus.iorq_n && bus.m1_n && !bus.rd_n && io_hit;
    io_wr_act = !bus.iorq_n && bus.m1_n && !bus.wr_n;
    io_wr_d   = io_wr_act;
    io_wr     = io_wr_act && !io_wr_q && io_hit;
    ack       = !bus.m1_n && !bus.iorq_n;
    eoi       = io_wr && (io_off[1:0] == REG_EOI);
    pend_rd   = 8'h00;
    pend_rd[NSRC-1:0] = pending_q;
    case (io_off[1:0])
      REG_MASK:  rd_data = mask_q;
      REG_VBASE: rd_data = vbase_q;
      REG_PEND:  rd_data = pend_rd;
      default:   rd_data = 8'h00;
    endcase
  end

`ifdef Z80_INTC_RETI_SNOOP_EN
  logic       fetch_q, fetch_d_w;
  logic [7:0] fbyte_q, fbyte_d;
  logic       ed_seen_q, ed_seen_d;
  logic       fetch_act, fetch_end;

  // RETI snoop: judge each opcode fetch by the byte seen on its last cycle
  always_comb begin
    fetch_act  = !bus.m1_n && !bus.mreq_n && !bus.rd_n;
    fetch_d_w  = fetch_act;
    fbyte_d    = fetch_act ? bus.fetch_d : fbyte_q;
    fetch_end  = fetch_q && !fetch_act;
    ed_seen_d  = ed_seen_q;
    reti_pulse = 1'b0;
    if (fetch_end) begin
      if (ed_seen_q) begin
        reti_pulse = (fbyte_q == OP_RETI);
        ed_seen_d  = 1'b0;
      end else begin
        ed_seen_d  = (fbyte_q == OP_ED);
      end
    end
  end

  // Snoop state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_q   <= 1'b0;
      fbyte_q   <= 8'h00;
      ed_seen_q <= 1'b0;
    end else begin
      fetch_q   <= fetch_d_w;
      fbyte_q   <= fbyte_d;
      ed_seen_q <= ed_seen_d;
    end
  end
`else
  assign reti_pulse = 1'b0;
`endif

  // Sequencer: raise int_n, take the ack, present the vector until iorq_n releases
  always_comb begin
    state_d   = state_q;
    int_n_d   = 1'b1;
    dout_en_d = io_rd;
    dout_d    = io_rd ? rd_data : 8'h00;
    ack_take  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ack) begin
          state_d  = ST_ACK;
          ack_take = 1'b1;
        end else if (win_vld) begin
          state_d = ST_REQ;
          int_n_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_d  = ST_ACK;
          ack_take = 1'b1;
        end else if (!win_vld) begin
          state_d = ST_IDLE;
        end else begin
          int_n_d = 1'b0;
        end
      end
      ST_ACK: begin
        dout_en_d = 1'b1;
        dout_d    = dout_q;
        if (bus.iorq_n) begin
          state_d   = ST_IDLE;
          dout_en_d = 1'b0;
          dout_d    = 8'h00;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ack_take) begin
      dout_en_d = 1'b1;
      dout_d    = win_vld ? mk_vector(vbase_q, win_idx) : SPURIOUS_VEC;
    end
  end

  // Register file, pending and in-service bookkeeping; a fresh edge beats an ack clear
  always_comb begin
    irq_d        = irq;
    mask_d       = mask_q;
    vbase_d      = vbase_q;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    if (io_wr && io_off[1:0] == REG_MASK)  mask_d  = bus.cpu_do;
    if (io_wr && io_off[1:0] == REG_VBASE) vbase_d = bus.cpu_do;
    if ((eoi || reti_pulse) && isv_vld) in_service_d[isv_idx] = 1'b0;
    if (ack_take && win_vld) begin
      pending_d[win_idx]    = 1'b0;
      in_service_d[win_idx] = 1'b1;
    end
    pending_d = pending_d | irq_edge;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= MASK_RST;
      vbase_q      <= 8'h00;
      dout_q       <= 8'h00;
      dout_en_q    <= 1'b0;
      int_n_q      <= 1'b1;
      io_wr_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      vbase_q      <= vbase_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      int_n_q      <= int_n_d;
      io_wr_q      <= io_wr_d;
    end
  end

endmodule

// File: doc/z80_int_ctrl.md
# z80_int_ctrl

Eight-source vectored interrupt controller for the TV80 core: latches peripheral requests, applies mask and fixed priority, drives the CPU `int_n` input and supplies the IM2 vector (IM0/IM1 byte) during the interrupt-acknowledge cycle. Sits directly upstream of the CPU interrupt pin and snoops the CPU bus. CPU-visible registers are reached through a small I/O port window.

## Interface
- `NSRC`, 8: number of request sources; bit 0 is highest priority. Max 8.
- `IO_BASE`, 8'hF0: base I/O port. +0 mask (RW), +1 vector base (RW), +2 EOI (W), +3 pending (R).
- `clk` in 1: single clock, all logic rising-edge.
- `reset_n` in 1: synchronous, active-low reset.
- `irq` in NSRC: peripheral requests, rising-edge sensitive, synchronous to `clk`.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n` in 1 each: CPU bus strobes.
- `addr` in 8: CPU A[7:0].
- `cpu_do` in 8: CPU write data.
- `fetch_d` in 8: byte the CPU is reading (for RETI snoop).
- `dout` out 8: data driven to the CPU read mux.
- `dout_en` out 1: `dout` valid; CPU mux selects this block.
- `int_n` out 1: registered, active-low interrupt request to CPU.

## Operation
- Reset values: mask=8'hFF, vbase=8'h00, pending=0, in_service=0, `int_n`=1, `dout`=8'h00, `dout_en`=0, FSM=IDLE.
- Edge detect: `irq` registered; `irq & ~irq_q` sets pending bit.
- Eligible = pending & ~mask, restricted to bits strictly higher priority than the highest set in_service bit. Winner = lowest eligible index.
- FSM IDLE: eligible≠0 -> REQ (`int_n`=0 next cycle).
- REQ: eligible drops to 0 (mask write, EOI-unrelated) -> IDLE, `int_n`=1. Ack detected (`m1_n`=0 & `iorq_n`=0) -> ACK.
- ACK entry: latch winner w; `dout`={vbase[7:4], w[2:0], 1'b0}; `dout_en`=1; pending[w]=0; in_service[w]=1; `int_n`=1. Stay in ACK while `iorq_n`=0; leave to IDLE when `iorq_n` returns 1, `dout_en`=0 same edge.
- Spurious ack (eligible=0 at ack entry): `dout`=8'hFF, no state change in pending/in_service.
- I/O read: `iorq_n`=0, `m1_n`=1, `rd_n`=0, addr in window -> `dout_en`=1, `dout`=register (+2 reads 8'h00). I/O write: first cycle of `iorq_n`=0 & `wr_n`=0 with addr in window performs write once.
- EOI write: clears highest-priority set in_service bit; data ignored.
- Simultaneous irq edge and ack of same source: pending remains set (new request wins over clear).
- Reset mid-ACK: all state to reset values next edge; `dout_en` drops.

## Timing
- Request latency: `irq` rise at edge N -> pending at N+1 -> `int_n`=0 at N+2 (unmasked, no blocking in_service).
- Ack detection -> `dout_en`=1 and `int_n`=1 one cycle later; holds until `iorq_n` deasserts.
- Register write effect visible on eligibility the cycle after the write.

## Configuration
- `Z80_INTC_RETI_SNOOP_EN`: when defined, an opcode fetch (`m1_n`=0, `mreq_n`=0, `rd_n`=0) of 8'hED immediately followed by the next M1 fetch of 8'h4D clears the highest set in_service bit, exactly as an EOI write; any other second byte cancels. When undefined, only EOI writes clear in_service and `fetch_d` is unused.

## Structure
- Package `z80_intc_pkg`: FSM state enum (IDLE, REQ, ACK), register offset constants, spurious vector constant.
- Sub-module `z80_intc_prio`: combinational priority encoder (eligible vector -> valid + index), instantiated twice (winner, highest in_service).

## Test plan
- Reset: after `reset_n` low one cycle -> mask=FF, `int_n`=1, `dout_en`=0, port +3 reads 00.
- Mask F7 written, vbase 40; pulse `irq[3]` -> `int_n`=0 two cycles later; ack -> `dout`=8'h46, `int_n`=1, port +3 reads 00.
- Mask 00; `irq[5]` serviced, then `irq[2]` edge -> `int_n`=0 (preempts); `irq[6]` edge -> no `int_n` until EOI clears bit 5.
- `int_n` low for source 4, then mask write FF before ack -> `int_n`=1 next cycle; forced ack -> `dout`=8'hFF.
- With `Z80_INTC_RETI_SNOOP_EN`: in_service=bit1, fetches ED,4D -> in_service=0; fetches ED,45 -> unchanged.
- IM1 flow (core IMode=1): `irq[0]` -> CPU vectors to 0x0038, SP=FFFE; ISR writes EOI -> in_service=0.
